// File: rtl/hpu_regif_axil_mst_pkg.sv
// rtl/hpu_regif_axil_mst_pkg.sv - shared types and constants for the AXI4-lite register master
package hpu_regif_axil_mst_pkg;

  // Stand-ins for the shell AXI-lite widths so this slice builds on its own.
  localparam int DEF_AXIL_ADD_W  = 32;
  localparam int DEF_AXIL_DATA_W = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_REQ = 3'd1,
    ST_WR_RSP = 3'd2,
    ST_RD_REQ = 3'd3,
    ST_RD_RSP = 3'd4,
    ST_RSP    = 3'd5
  } state_e;

  typedef struct packed {
    logic                       wr;
    logic [DEF_AXIL_ADD_W-1:0]  addr;
    logic [DEF_AXIL_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/hpu_regif_axil_mst.sv
// rtl/hpu_regif_axil_mst.sv - single-outstanding AXI4-lite master, optional watchdog via HPU_REGIF_AXIL_MST_TIMEOUT_EN
module hpu_regif_axil_mst
  import hpu_regif_axil_mst_pkg::*;
#(
  parameter int AXIL_ADD_W  = DEF_AXIL_ADD_W,
  parameter int AXIL_DATA_W = DEF_AXIL_DATA_W,
  parameter int ERR_CNT_W   = 8
`ifdef HPU_REGIF_AXIL_MST_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic                   clk,
  input  logic                   s_rst,
  input  logic                   cmd_vld,
  output logic                   cmd_rdy,
  input  logic                   cmd_wr,
  input  logic [AXIL_ADD_W-1:0]  cmd_addr,
  input  logic [AXIL_DATA_W-1:0] cmd_wdata,
  output logic                   rsp_vld,
  input  logic                   rsp_rdy,
  output logic [AXIL_DATA_W-1:0] rsp_rdata,
  output logic [1:0]             rsp_resp,
  output logic [AXIL_ADD_W-1:0]  m_axil_awaddr,
  output logic                   m_axil_awvalid,
  input  logic                   m_axil_awready,
  output logic [AXIL_DATA_W-1:0] m_axil_wdata,
  output logic                   m_axil_wvalid,
  input  logic                   m_axil_wready,
  input  logic [1:0]             m_axil_bresp,
  input  logic                   m_axil_bvalid,
  output logic                   m_axil_bready,
  output logic [AXIL_ADD_W-1:0]  m_axil_araddr,
  output logic                   m_axil_arvalid,
  input  logic                   m_axil_arready,
  input  logic [AXIL_DATA_W-1:0] m_axil_rdata,
  input  logic [1:0]             m_axil_rresp,
  input  logic                   m_axil_rvalid,
  output logic                   m_axil_rready,
  output logic                   busy,
  output logic [ERR_CNT_W-1:0]   err_cnt
`ifdef HPU_REGIF_AXIL_MST_TIMEOUT_EN
  ,
  output logic                   timeout_err
`endif
);

  state_e                 r_state;
  logic                   r_awvalid;
  logic                   r_wvalid;
  logic [AXIL_ADD_W-1:0]  r_addr;
  logic [AXIL_DATA_W-1:0] r_wdata;
  logic [AXIL_DATA_W-1:0] r_rdata;
  logic [1:0]             r_resp;
  logic [ERR_CNT_W-1:0]   r_err_cnt;

  logic                   w_cap_vld;
  logic [1:0]             w_cap_resp;

  // Response capture: only honoured in the state that owns the matching ready.
  always_comb begin
    w_cap_vld  = 1'b0;
    w_cap_resp = AXI_RESP_OKAY;
    if (r_state == ST_WR_RSP && m_axil_bvalid) begin
      w_cap_vld  = 1'b1;
      w_cap_resp = m_axil_bresp;
    end else if (r_state == ST_RD_RSP && m_axil_rvalid) begin
      w_cap_vld  = 1'b1;
      w_cap_resp = m_axil_rresp;
    end
  end

  // Transaction FSM: AW and W are retired independently, response is held until taken.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      r_state   <= ST_IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_resp    <= AXI_RESP_OKAY;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_vld) begin
            r_addr  <= cmd_addr;
            r_wdata <= cmd_wdata;
            if (cmd_wr) begin
              r_state   <= ST_WR_REQ;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_state <= ST_RD_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          if (r_awvalid && m_axil_awready) r_awvalid <= 1'b0;
          if (r_wvalid && m_axil_wready)   r_wvalid  <= 1'b0;
          if ((!r_awvalid || m_axil_awready) && (!r_wvalid || m_axil_wready))
            r_state <= ST_WR_RSP;
        end
        ST_WR_RSP: begin
          if (w_cap_vld) begin
            r_rdata <= '0;
            r_resp  <= w_cap_resp;
            r_state <= ST_RSP;
          end
        end
        ST_RD_REQ: begin
          if (m_axil_arready) r_state <= ST_RD_RSP;
        end
        ST_RD_RSP: begin
          if (w_cap_vld) begin
            r_rdata <= m_axil_rdata;
            r_resp  <= w_cap_resp;
            r_state <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_rdy) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Saturating count of non-OKAY responses.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      r_err_cnt <= '0;
    end else if (w_cap_vld && w_cap_resp != AXI_RESP_OKAY && r_err_cnt != '1) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign cmd_rdy        = (r_state == ST_IDLE);
  assign busy           = (r_state != ST_IDLE);
  assign rsp_vld        = (r_state == ST_RSP);
  assign rsp_rdata      = r_rdata;
  assign rsp_resp       = r_resp;
  assign m_axil_awaddr  = r_addr;
  assign m_axil_awvalid = r_awvalid;
  assign m_axil_wdata   = r_wdata;
  assign m_axil_wvalid  = r_wvalid;
  assign m_axil_bready  = (r_state == ST_WR_RSP);
  assign m_axil_araddr  = r_addr;
  assign m_axil_arvalid = (r_state == ST_RD_REQ);
  assign m_axil_rready  = (r_state == ST_RD_RSP);
  assign err_cnt        = r_err_cnt;

`ifdef HPU_REGIF_AXIL_MST_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  state_e          r_prev_state;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout_err;
  logic            w_to_active;
  logic [TO_W-1:0] w_to_done;

  // Cycles completed in the current waiting state, restarting on every state entry.
  always_comb begin
    w_to_active = (r_state == ST_WR_REQ) || (r_state == ST_WR_RSP) ||
                  (r_state == ST_RD_REQ) || (r_state == ST_RD_RSP);
    if (r_state != r_prev_state)
      w_to_done = TO_W'(1);
    else if (r_to_cnt == TO_W'(TIMEOUT_CYC))
      w_to_done = r_to_cnt;
    else
      w_to_done = r_to_cnt + TO_W'(1);
  end

  // Watchdog: flags a stalled slave but never aborts the handshake in flight.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      r_prev_state  <= ST_IDLE;
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_prev_state <= r_state;
      r_to_cnt     <= w_to_active ? w_to_done : '0;
      if (w_to_active && w_to_done == TO_W'(TIMEOUT_CYC)) r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`endif

endmodule

// File: tb/tb_hpu_regif_axil_mst.sv
// tb/tb_hpu_regif_axil_mst.sv - directed bench for hpu_regif_axil_mst with a behavioural AXI-lite slave
module tb_hpu_regif_axil_mst;
  import hpu_regif_axil_mst_pkg::*;

  logic        clk = 1'b0;
  logic        s_rst;
  logic        cmd_vld, cmd_rdy, cmd_wr;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_vld, rsp_rdy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic        busy;
  logic [7:0]  err_cnt;
`ifdef HPU_REGIF_AXIL_MST_TIMEOUT_EN
  logic        timeout_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

`ifdef HPU_REGIF_AXIL_MST_TIMEOUT_EN
  hpu_regif_axil_mst #(.AXIL_ADD_W(32), .AXIL_DATA_W(32), .ERR_CNT_W(8), .TIMEOUT_CYC(16)) dut (
`else
  hpu_regif_axil_mst #(.AXIL_ADD_W(32), .AXIL_DATA_W(32), .ERR_CNT_W(8)) dut (
`endif
    .clk(clk), .s_rst(s_rst),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready),
    .busy(busy), .err_cnt(err_cnt)
`ifdef HPU_REGIF_AXIL_MST_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  // Slave: ready on the Nth cycle of valid, registered response one cycle after the handshake.
  int          aw_dly = 1, w_dly = 1, ar_dly = 1;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  int          aw_wait, w_wait, ar_wait;
  logic        aw_got, w_got;
  logic [31:0] sl_awaddr, sl_wdata;
  logic [31:0] mem [16];
  logic [31:0] wr_addr_m, wr_data_m;

  assign awready   = awvalid && (aw_wait >= aw_dly - 1);
  assign wready    = wvalid  && (w_wait  >= w_dly  - 1);
  assign arready   = arvalid && (ar_wait >= ar_dly - 1);
  assign wr_addr_m = aw_got ? sl_awaddr : awaddr;
  assign wr_data_m = w_got  ? sl_wdata  : wdata;

  always @(posedge clk) begin
    if (s_rst) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00;
      rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
      mem[1] <= 32'h1234_5678;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait  <= (wvalid  && !wready)  ? w_wait  + 1 : 0;
      ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
      if (awvalid && awready) begin aw_got <= 1'b1; sl_awaddr <= awaddr; end
      if (wvalid && wready)   begin w_got  <= 1'b1; sl_wdata  <= wdata;  end
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) && !bvalid) begin
        mem[wr_addr_m[5:2]] <= wr_data_m;
        bvalid <= 1'b1;
        bresp  <= cfg_bresp;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= mem[araddr[5:2]];
        rresp  <= cfg_rresp;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!cmd_rdy && n < 100) begin @(negedge clk); n++; end
    if (!cmd_rdy) check("wait_idle_timeout", 0, 1);
  endtask

  // One transaction with rsp_rdy held high; lat counts cycles from accept to rsp_vld.
  task automatic do_txn(input cmd_t c, output logic [31:0] d, output logic [1:0] r, output int lat);
    wait_idle();
    cmd_vld = 1'b1; cmd_wr = c.wr; cmd_addr = c.addr; cmd_wdata = c.wdata; rsp_rdy = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    lat = 1;
    while (!rsp_vld && lat < 100) begin @(negedge clk); lat++; end
    if (!rsp_vld) check("rsp_timeout", 0, 1);
    d = rsp_rdata;
    r = rsp_resp;
  endtask

  logic [31:0] d;
  logic [1:0]  r;
  int          lat;
  logic [31:0] hold_d;
  cmd_t        c;

  initial begin
    s_rst = 1'b1; cmd_vld = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_rdy", cmd_rdy, 1);
    check("rst_rsp_vld", rsp_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    check("rst_err_cnt", err_cnt, 0);
    s_rst = 1'b0;

    // Zero-wait write, cycle by cycle.
    @(negedge clk);
    cmd_vld = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h0000_1000; cmd_wdata = 32'hDEAD_BEEF; rsp_rdy = 1'b1;
    @(negedge clk); cmd_vld = 1'b0;
    check("wr0_c1_aw_w_valid", {awvalid, wvalid}, 2'b11);
    check("wr0_c1_awaddr", awaddr, 32'h0000_1000);
    check("wr0_c1_wdata", wdata, 32'hDEAD_BEEF);
    check("wr0_c1_cmd_rdy_busy", {cmd_rdy, busy}, 2'b01);
    @(negedge clk);
    check("wr0_c2_valids_bready", {awvalid, wvalid, bready}, 3'b001);
    check("wr0_c2_rsp_vld", rsp_vld, 0);
    @(negedge clk);
    check("wr0_c3_rsp_vld", rsp_vld, 1);
    check("wr0_c3_rsp", {rsp_rdata, rsp_resp}, {32'h0, 2'b00});
    check("wr0_c3_bready", bready, 0);
    @(negedge clk);
    check("wr0_c4_cmd_rdy", {cmd_rdy, rsp_vld}, 2'b10);
    check("wr0_mem", mem[0], 32'hDEAD_BEEF);

    // Write with awready on the 3rd cycle and wready on the 1st.
    aw_dly = 3; w_dly = 1;
    cmd_vld = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h0000_1008; cmd_wdata = 32'hCAFE_0001;
    @(negedge clk); cmd_vld = 1'b0;
    check("wr1_c1", {awvalid, wvalid, bready}, 3'b110);
    @(negedge clk);
    check("wr1_c2", {awvalid, wvalid, bready}, 3'b100);
    @(negedge clk);
    check("wr1_c3", {awvalid, wvalid, bready}, 3'b100);
    @(negedge clk);
    check("wr1_c4", {awvalid, wvalid, bready}, 3'b001);
    @(negedge clk);
    check("wr1_c5_rsp", {rsp_vld, rsp_resp}, 3'b100);
    check("wr1_mem", mem[2], 32'hCAFE_0001);
    aw_dly = 1;

    // Reads: preloaded word, then read-back of the first write.
    c = '{wr: 1'b0, addr: 32'h0000_1004, wdata: 32'h0};
    do_txn(c, d, r, lat);
    check("rd0_rdata", d, 32'h1234_5678);
    check("rd0_resp", r, 2'b00);
    check("rd0_latency", lat, 3);
    c = '{wr: 1'b0, addr: 32'h0000_1000, wdata: 32'h0};
    do_txn(c, d, r, lat);
    check("rd1_readback", d, 32'hDEAD_BEEF);

    // SLVERR storm saturates the error counter.
    cfg_rresp = 2'b10;
    for (int i = 0; i < 300; i++) begin
      c = '{wr: 1'b0, addr: 32'h0000_1004, wdata: 32'h0};
      do_txn(c, d, r, lat);
      check($sformatf("err_resp_%0d", i), r, 2'b10);
      if (i == 0 || i == 253 || i == 254 || i == 255 || i == 299)
        check($sformatf("err_cnt_%0d", i), err_cnt, (i + 1 > 255) ? 255 : i + 1);
    end
    cfg_rresp = 2'b00;

    // Response held off for 10 cycles.
    wait_idle();
    rsp_rdy = 1'b0;
    cmd_vld = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h0000_1004;
    @(negedge clk); cmd_vld = 1'b0;
    lat = 1;
    while (!rsp_vld && lat < 20) begin @(negedge clk); lat++; end
    check("hold_rsp_seen", rsp_vld, 1);
    hold_d = rsp_rdata;
    check("hold_rdata", hold_d, 32'h1234_5678);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold_%0d", i), {rsp_vld, cmd_rdy, rsp_rdata, rsp_resp}, {1'b1, 1'b0, 32'h1234_5678, 2'b00});
    end
    rsp_rdy = 1'b1;
    @(negedge clk);
    check("hold_release", {rsp_vld, cmd_rdy}, 2'b01);

    // Reset while stuck in WR_REQ.
    aw_dly = 10;
    cmd_vld = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h0000_100C; cmd_wdata = 32'h5555_AAAA;
    @(negedge clk); cmd_vld = 1'b0;
    check("rstmid_in_wr_req", {awvalid, wvalid}, 2'b11);
    s_rst = 1'b1;
    @(negedge clk);
    check("rstmid_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_vld}, 0);
    check("rstmid_cmd_rdy_busy", {cmd_rdy, busy}, 2'b10);
    check("rstmid_err_cnt", err_cnt, 0);
    s_rst = 1'b0; aw_dly = 1;
    c = '{wr: 1'b1, addr: 32'h0000_100C, wdata: 32'h0BAD_F00D};
    do_txn(c, d, r, lat);
    check("post_rst_wr_lat", lat, 3);
    check("post_rst_mem", mem[3], 32'h0BAD_F00D);

`ifdef HPU_REGIF_AXIL_MST_TIMEOUT_EN
    // arready withheld for 20 cycles against a 16-cycle watchdog.
    wait_idle();
    ar_dly = 21;
    check("to_initial", timeout_err, 0);
    cmd_vld = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h0000_1004;
    @(negedge clk); cmd_vld = 1'b0;
    repeat (15) @(negedge clk);
    check("to_cycle16", {timeout_err, arvalid}, 2'b01);
    @(negedge clk);
    check("to_cycle17", {timeout_err, arvalid}, 2'b11);
    lat = 0;
    while (!rsp_vld && lat < 40) begin @(negedge clk); lat++; end
    check("to_rsp", {rsp_vld, rsp_resp, rsp_rdata}, {1'b1, 2'b00, 32'h1234_5678});
    @(negedge clk);
    check("to_sticky", timeout_err, 1);
    ar_dly = 1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hpu_regif_axil_mst.md
Name: hpu_regif_axil_mst

Overview:
- AXI4-lite master (initiator) that issues single register reads and writes towards an hpu_regif_core_* slave, e.g. the 1in3 config bank holding the HBM addresses and the BPIP settings.
- Driven by a simple command/response valid-ready interface, used by boot/config sequencers and test harnesses.
- One transaction outstanding at a time. Write data and write address are issued concurrently. Error responses are counted.

Parameters:
- AXIL_ADD_W, axi_if_shell_axil_pkg::AXIL_ADD_W, AXI-lite address width.
- AXIL_DATA_W, axi_if_shell_axil_pkg::AXIL_DATA_W, AXI-lite data width (32).
- TIMEOUT_CYC, 1024, watchdog threshold in cycles (used only with the optional feature).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock
- s_rst  in  1  synchronous active-high reset
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command ready
- cmd_wr  in  1  1=write, 0=read
- cmd_addr  in  AXIL_ADD_W  byte address
- cmd_wdata  in  AXIL_DATA_W  write data
- rsp_vld  out  1  response valid
- rsp_rdy  in  1  response ready
- rsp_rdata  out  AXIL_DATA_W  read data (0 for writes)
- rsp_resp  out  2  AXI resp of the transaction
- m_axil_aw{addr,valid,ready}, m_axil_w{data,valid,ready}, m_axil_b{resp,valid,ready}, m_axil_ar{addr,valid,ready}, m_axil_r{data,resp,valid,ready}  standard AXI4-lite master directions/widths
- busy  out  1  FSM not in IDLE
- err_cnt  out  ERR_CNT_W  number of non-OKAY responses, saturating

Behaviour:
- Reset value of every output is 0, with one exception: cmd_rdy=1 after reset (IDLE). Reset mid-transaction returns the FSM to IDLE immediately and drops all valids; the slave is reset together with this block.
- FSM states: IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, RSP.
- IDLE: cmd_rdy=1. On cmd_vld&cmd_rdy, capture addr/wdata/wr.
  - Write: go to WR_REQ with awvalid=1 and wvalid=1 from the next cycle.
  - Read: go to RD_REQ with arvalid=1.
- WR_REQ: awvalid and wvalid are cleared independently on their own handshake and are never dropped before ready. When both are done (including on the same cycle), go to WR_RSP with bready=1.
- WR_RSP: on bvalid, capture bresp, set rsp_rdata=0, go to RSP. bready=1 only in this state.
- RD_REQ: on arready, go to RD_RSP with rready=1.
- RD_RSP: on rvalid, capture rdata and rresp, go to RSP.
- RSP: rsp_vld=1 and outputs stable until rsp_rdy. On rsp_rdy, go to IDLE. cmd_rdy is 0 here, so there is no back-to-back overlap.
- Minimum latency for a zero-wait slave (ready=1, response on the cycle after the handshake):
  - cmd accept to rsp_vld is 3 cycles.
  - cmd accept to next cmd_rdy is 4 cycles when rsp_rdy=1.
- aw/w/ar addr and data are driven from registers, constant while valid.
- err_cnt increments when a response is captured with resp!=2'b00. It saturates at all-ones.
- Unexpected bvalid/rvalid outside WR_RSP/RD_RSP is ignored; ready is 0 there.

Optional Feature:
- Macro: HPU_REGIF_AXIL_MST_TIMEOUT_EN.
- When defined:
  - A counter resets on every state entry and increments while in WR_REQ/WR_RSP/RD_REQ/RD_RSP.
  - On reaching TIMEOUT_CYC, an extra output port timeout_err (1 bit) is set sticky; only s_rst clears it.
  - Valids are not aborted, so AXI rules are preserved.
- When undefined: no counter and no timeout_err port.

Decomposition:
- Shared package hpu_regif_axil_mst_pkg holds:
  - the FSM state enum;
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants;
  - a cmd_t struct {wr, addr, wdata}.
- No sub-module. A single module is natural at about 200 lines.

Test Plan:
- Write addr=0x0000_1000, wdata=0xDEAD_BEEF, slave awready=1, wready=1, bresp=OKAY -> aw/w fire together, one b handshake, rsp_vld with rsp_resp=0 and rsp_rdata=0; slave register reads back 0xDEAD_BEEF.
- Write with awready delayed 3 cycles and wready delayed 1 -> wvalid drops after 1 cycle, awvalid holds 3 cycles, bready is only asserted after both handshakes.
- Read addr=0x0000_1004, slave returns rdata=0x1234_5678, rresp=OKAY -> rsp_rdata=0x1234_5678, rsp_resp=0.
- Slave returns SLVERR on 300 consecutive reads (ERR_CNT_W=8) -> err_cnt saturates at 255 and every rsp_resp=2.
- rsp_rdy held low 10 cycles -> rsp_vld and data stable, cmd_rdy=0 throughout; s_rst asserted while in WR_REQ -> all valids 0 and cmd_rdy=1 on the next cycle.
- With HPU_REGIF_AXIL_MST_TIMEOUT_EN and TIMEOUT_CYC=16, arready held low 20 cycles -> timeout_err=1 at the 16th cycle, arvalid still high, transaction completes normally after arready.
